irom_flash_loader: RTL and testbench

- Upstream feeder for the instruction ROM.
- While FlashEnable is high, it pulls 16-bit instruction words from the off-chip I/O peripheral over the IOWaiting/IOReady parallel handshake and writes them sequentially into IROM starting at address 0.
- It holds the core's PC stalled for the whole load.
- It sits between the chip-level I/O pins and the IROM write port/Flash write enable.

---
 rtl/irom_flash_loader.sv | 122 ++++++++++++
 tb/tb_irom_flash_loader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/irom_flash_loader.sv
// Flash loader for the instruction ROM: while FlashEnable is high, pulls words from the
// parallel I/O peripheral and writes them sequentially into IROM from address 0, stalling the core.
module irom_flash_loader #(
   parameter int ADR_WIDTH  = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  FlashEnable,
   input  logic                  IOReady,
   input  logic [DATA_WIDTH-1:0] ParallelIn,
   output logic                  IOWaiting,
   output logic                  Flash,
   output logic [ADR_WIDTH-1:0]  FlashAdr,
   output logic [DATA_WIDTH-1:0] FlashData,
   output logic                  CoreHold,
   output logic                  FlashDone,
   output logic [ADR_WIDTH:0]    WordCount
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state_r;
   state_t                  state_s;
   logic [ADR_WIDTH-1:0]    adr_r;
   logic [ADR_WIDTH-1:0]    adr_s;
   logic [DATA_WIDTH-1:0]   data_r;
   logic [DATA_WIDTH-1:0]   data_s;
   logic [ADR_WIDTH:0]      count_r;
   logic [ADR_WIDTH:0]      count_s;
   logic                    waiting_r;
   logic                    flash_r;
   logic                    hold_r;
   logic                    done_r;

   // Next-state, address, data and count decode.
   always_comb begin
      state_s = state_r;
      adr_s   = adr_r;
      data_s  = data_r;
      count_s = count_r;
      case (state_r)
         IDLE: begin
            if (FlashEnable) begin
               state_s = WAIT;
               adr_s   = {ADR_WIDTH{1'b0}};
               count_s = {(ADR_WIDTH+1){1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            // A release of FlashEnable wins over a word offered in the same cycle.
            if (!FlashEnable) begin
               state_s = DONE;
            end else if (IOReady) begin
               data_s  = ParallelIn;
               state_s = WRITE;
            end else begin
               state_s = WAIT;
            end
         end
         WRITE: begin
            count_s = count_r + {{ADR_WIDTH{1'b0}}, 1'b1};
            if (adr_r == {ADR_WIDTH{1'b1}}) begin
               state_s = DONE;
            end else begin
               adr_s   = adr_r + {{(ADR_WIDTH-1){1'b0}}, 1'b1};
               state_s = WAIT;
            end
         end
         DONE: begin
            if (!FlashEnable) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and output flag registers; flags are decoded from the next state so
   // they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         adr_r     <= {ADR_WIDTH{1'b0}};
         data_r    <= {DATA_WIDTH{1'b0}};
         count_r   <= {(ADR_WIDTH+1){1'b0}};
         waiting_r <= 1'b0;
         flash_r   <= 1'b0;
         hold_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         adr_r     <= adr_s;
         data_r    <= data_s;
         count_r   <= count_s;
         waiting_r <= (state_s == WAIT);
         flash_r   <= (state_s == WRITE);
         hold_r    <= (state_s != IDLE);
         done_r    <= (state_s == DONE);
      end
   end

   assign IOWaiting = waiting_r;
   assign Flash     = flash_r;
   assign FlashAdr  = adr_r;
   assign FlashData = data_r;
   assign CoreHold  = hold_r;
   assign FlashDone = done_r;
   assign WordCount = count_r;

endmodule

// File: tb/tb_irom_flash_loader.sv
// Self-checking bench for irom_flash_loader: a scoreboard queue holds expected IROM writes,
// a negedge monitor pops one per Flash pulse; status outputs are checked directly.
module tb_irom_flash_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        FlashEnable;
   logic        IOReady;
   logic [15:0] ParallelIn;
   logic        IOWaiting;
   logic        Flash;
   logic [7:0]  FlashAdr;
   logic [15:0] FlashData;
   logic        CoreHold;
   logic        FlashDone;
   logic [8:0]  WordCount;

   int errors = 0;
   int checks = 0;
   int exp_adr = 0;
   logic [23:0] sb[$];

   irom_flash_loader #(.ADR_WIDTH(8), .DATA_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .FlashEnable(FlashEnable), .IOReady(IOReady),
      .ParallelIn(ParallelIn), .IOWaiting(IOWaiting), .Flash(Flash), .FlashAdr(FlashAdr),
      .FlashData(FlashData), .CoreHold(CoreHold), .FlashDone(FlashDone), .WordCount(WordCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] pat(input int i);
      logic [15:0] v;
      v = 16'(i * 257) ^ 16'h5A3C;
      return v;
   endfunction

   // Offer one word on the next IOWaiting, expecting it to be written at exp_adr.
   task automatic feed(input logic [15:0] w);
      int n = 0;
      while (!IOWaiting && n < 20) begin
         cyc();
         n++;
      end
      chk("feed_iowaiting", 32'(IOWaiting), 32'd1);
      if (IOWaiting) begin
         sb.push_back({8'(exp_adr), w});
         exp_adr++;
         ParallelIn = w;
         IOReady    = 1'b1;
         cyc();
         IOReady    = 1'b0;
      end
   endtask

   // Scoreboard monitor: every Flash pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (Flash === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_flash", {8'h00, FlashAdr, FlashData}, 32'hFFFFFFFF);
         end else begin
            logic [23:0] e;
            e = sb.pop_front();
            chk("flash_adr", 32'(FlashAdr), 32'(e[23:16]));
            chk("flash_data", 32'(FlashData), 32'(e[15:0]));
         end
      end
   end

   initial begin
      reset = 1'b1; FlashEnable = 1'b0; IOReady = 1'b0; ParallelIn = 16'h0000;
      cyc(); cyc();
      reset = 1'b0;
      cyc();
      chk("rst_iowaiting", 32'(IOWaiting), 32'd0);
      chk("rst_coreHold", 32'(CoreHold), 32'd0);
      chk("rst_done", 32'(FlashDone), 32'd0);
      chk("rst_adr", 32'(FlashAdr), 32'd0);
      chk("rst_data", 32'(FlashData), 32'd0);
      chk("rst_count", 32'(WordCount), 32'd0);

      // Three-word load, FlashEnable dropped during the last WRITE.
      exp_adr = 0; FlashEnable = 1'b1;
      feed(16'h1A05); feed(16'h2B06); feed(16'h0000);
      FlashEnable = 1'b0;
      cyc();
      chk("t1_wait_count", 32'(WordCount), 32'd3);
      chk("t1_wait_iowaiting", 32'(IOWaiting), 32'd1);
      cyc();
      chk("t1_done", 32'(FlashDone), 32'd1);
      chk("t1_done_hold", 32'(CoreHold), 32'd1);
      cyc();
      chk("t1_idle_done", 32'(FlashDone), 32'd0);
      chk("t1_idle_hold", 32'(CoreHold), 32'd0);
      chk("t1_idle_count", 32'(WordCount), 32'd3);

      // Full 256-word load with IOReady held high.
      exp_adr = 0; FlashEnable = 1'b1;
      cyc();
      for (int i = 0; i < 256; i++) begin
         ParallelIn = pat(i);
         IOReady    = 1'b1;
         sb.push_back({8'(i), pat(i)});
         cyc();
         if (i == 0) chk("t2_write_iowaiting", 32'(IOWaiting), 32'd0);
         cyc();
      end
      chk("t2_done", 32'(FlashDone), 32'd1);
      chk("t2_count", 32'(WordCount), 32'd256);
      chk("t2_adr", 32'(FlashAdr), 32'd255);
      chk("t2_data", 32'(FlashData), 32'(pat(255)));
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t2_done_iowaiting", 32'(IOWaiting), 32'd0);
      end
      FlashEnable = 1'b0; IOReady = 1'b0;
      cyc();
      chk("t2_idle_hold", 32'(CoreHold), 32'd0);

      // FlashEnable falls together with IOReady in WAIT: word discarded.
      exp_adr = 0; FlashEnable = 1'b1;
      feed(16'h3C07);
      cyc();
      FlashEnable = 1'b0; IOReady = 1'b1; ParallelIn = 16'hDEAD;
      cyc();
      IOReady = 1'b0;
      chk("t3_done", 32'(FlashDone), 32'd1);
      chk("t3_count", 32'(WordCount), 32'd1);
      chk("t3_data", 32'(FlashData), 32'h3C07);
      cyc();

      // Sync reset during the WRITE of the fifth word.
      exp_adr = 0; FlashEnable = 1'b1;
      for (int i = 0; i < 5; i++) feed(16'(16'h1100 + i));
      reset = 1'b1;
      cyc();
      reset = 1'b0; FlashEnable = 1'b0;
      chk("t4_iowaiting", 32'(IOWaiting), 32'd0);
      chk("t4_flash", 32'(Flash), 32'd0);
      chk("t4_hold", 32'(CoreHold), 32'd0);
      chk("t4_done", 32'(FlashDone), 32'd0);
      chk("t4_adr", 32'(FlashAdr), 32'd0);
      chk("t4_data", 32'(FlashData), 32'd0);
      chk("t4_count", 32'(WordCount), 32'd0);
      cyc();
      exp_adr = 0; FlashEnable = 1'b1;
      feed(16'h4D08);
      cyc();

      // Enter DONE by a release, then hold FlashEnable high with IOReady toggling.
      FlashEnable = 1'b0;
      cyc();
      FlashEnable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         IOReady = ((8'b10110110 >> i) & 8'd1) != 8'd0;
         ParallelIn = 16'(16'hBEE0 + i);
         cyc();
         chk("t5_iowaiting", 32'(IOWaiting), 32'd0);
         chk("t5_done", 32'(FlashDone), 32'd1);
      end
      chk("t5_count", 32'(WordCount), 32'd1);
      IOReady = 1'b0; FlashEnable = 1'b0;
      cyc();
      chk("t5_idle", 32'(CoreHold), 32'd0);
      exp_adr = 0; FlashEnable = 1'b1;
      cyc();
      chk("t5_new_count", 32'(WordCount), 32'd0);
      chk("t5_new_adr", 32'(FlashAdr), 32'd0);

      // IOReady stalls for 10 cycles in WAIT.
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("t6_iowaiting", 32'(IOWaiting), 32'd1);
         chk("t6_hold", 32'(CoreHold), 32'd1);
         chk("t6_adr", 32'(FlashAdr), 32'd0);
      end
      feed(16'h5E09);
      FlashEnable = 1'b0;
      cyc(); cyc();
      chk("t6_done", 32'(FlashDone), 32'd1);
      chk("t6_count", 32'(WordCount), 32'd1);
      cyc(); cyc();
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
